// File: rtl/apb_pkg.sv
// Shared APB types: completer FSM states, address alignment constant and the
// ready/slverr response pair used by the register-bank completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_t;

    // Registers are word-spaced; the low address bits select bytes and are ignored.
    localparam int APB_ADDR_LSB = 2;

    typedef struct packed {
        logic ready;
        logic slverr;
    } apb_resp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state down-counter for the APB completer. Loaded with the wait count
// when a transfer enters SETUP, counts down while ACCESS is active, and flags
// done once it reaches zero.
module apb_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Counter: reset clears, load takes priority over decrement, stops at zero.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer register bank. NUM_REGS words at BASE_ADDR; word 0 returns the
// constant ID_VALUE and ignores writes, the rest are read/write. Each transfer
// inserts WAIT_CYCLES ACCESS cycles before pready_o.
// Optional feature: define APB_REG_SLAVE_PSLVERR_EN to drive pslverr_o on a
// miss access or a write to word 0; without it pslverr_o is tied low and those
// accesses complete silently with the same write suppression.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hDEADCAE0,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B00001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              pen_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam int                IDX_W        = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] REGION_BYTES = ADDR_W'(NUM_REGS << APB_ADDR_LSB);
    localparam logic [3:0]        WAIT_LOAD    = 4'(WAIT_CYCLES);

    apb_slv_state_t    r_state;
    apb_slv_state_t    w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [ADDR_W-1:0] w_offset;
    logic              w_hit;
    logic [IDX_W-1:0]  w_index;
    logic              w_err_case;
    logic              w_load;
    logic              w_timer_done;
    logic              w_commit;
    logic [DATA_W-1:0] w_rdata;
    apb_resp_t         w_resp;

    // Decode of the address captured in SETUP; an address below the base wraps
    // to a large offset and therefore misses as well.
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_hit      = (w_offset < REGION_BYTES);
    assign w_index    = w_offset[APB_ADDR_LSB +: IDX_W];
    assign w_err_case = !w_hit || (r_write && (w_index == '0));

    // Capture the request (and reload the wait timer) whenever the next state is SETUP.
    assign w_load = (w_next == SETUP);

    apb_wait_timer #(
        .CNT_W (4)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (WAIT_LOAD),
        .i_en       (r_state == ACCESS),
        .o_done     (w_timer_done)
    );

    // Next-state logic for the IDLE/SETUP/ACCESS protocol tracker.
    // NOTE: w_next is assigned a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (psel_i && !pen_i) w_next = SETUP;
            end
            SETUP: begin
                if (!psel_i)    w_next = IDLE;
                else if (pen_i) w_next = ACCESS;
            end
            ACCESS: begin
                if (w_timer_done) w_next = (psel_i && !pen_i) ? SETUP : IDLE;
                else if (!psel_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Request capture during the setup phase; values are held through ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_addr  <= paddr_i;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
        end
    end

    // Completion response and read data, all combinational from state and timer.
    always_comb begin
        w_resp.ready = (r_state == ACCESS) && w_timer_done;
`ifdef APB_REG_SLAVE_PSLVERR_EN
        w_resp.slverr = w_resp.ready && w_err_case;
`else
        w_resp.slverr = 1'b0;
`endif
        w_rdata = '0;
        if (w_resp.ready && !r_write && w_hit) begin
            w_rdata = (w_index == '0) ? ID_VALUE : r_regs[w_index];
        end
    end

    assign w_commit = w_resp.ready && r_write && !w_err_case;

    // Register file: the write lands on the edge that ends the ready cycle.
    // NOTE: this storage is reset explicitly because software relies on
    // registers reading zero after reset; a plain RAM would not be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[w_index] <= r_wdata;
        end
    end

    assign prdata_o  = w_rdata;
    assign pready_o  = w_resp.ready;
    assign pslverr_o = w_resp.slverr;

endmodule
